// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe computer opponent: cell codes,
// line table, fallback order and FSM state encoding.
package ttt_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY    = 2'b00,
    CELL_PLAYER   = 2'b01,
    CELL_COMPUTER = 2'b10,
    CELL_BLOCKED  = 2'b11
  } cell_e;

  typedef enum logic [7:0] {
    S_WAIT_PLAYER = 8'b0000_0001,
    S_OPEN        = 8'b0000_0010,
    S_SETTLE      = 8'b0000_0100,
    S_SCAN_WIN    = 8'b0000_1000,
    S_SCAN_BLOCK  = 8'b0001_0000,
    S_PICK        = 8'b0010_0000,
    S_ISSUE       = 8'b0100_0000,
    S_GAME_OVER   = 8'b1000_0000
  } state_e;

  // Cell address (1..9) of position pos (0..2) within line idx.
  function automatic logic [3:0] line_cell(input logic [2:0] idx, input logic [1:0] pos);
    logic [11:0] l;
    case (idx)
      3'd0:    l = {4'd1, 4'd2, 4'd3};
      3'd1:    l = {4'd4, 4'd5, 4'd6};
      3'd2:    l = {4'd7, 4'd8, 4'd9};
      3'd3:    l = {4'd1, 4'd4, 4'd7};
      3'd4:    l = {4'd2, 4'd5, 4'd8};
      3'd5:    l = {4'd3, 4'd6, 4'd9};
      3'd6:    l = {4'd1, 4'd5, 4'd9};
      default: l = {4'd3, 4'd5, 4'd7};
    endcase
    case (pos)
      2'd0:    return l[11:8];
      2'd1:    return l[7:4];
      default: return l[3:0];
    endcase
  endfunction

  // Fallback priority: centre, corners, then edges.
  function automatic logic [3:0] pick_cell(input int i);
    case (i)
      0:       return 4'd5;
      1:       return 4'd1;
      2:       return 4'd3;
      3:       return 4'd7;
      4:       return 4'd9;
      5:       return 4'd2;
      6:       return 4'd4;
      7:       return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/ttt_line_eval.sv
// Evaluates one board line: hit when two cells belong to `side` and the
// third is empty; empty_idx names the free position.
module ttt_line_eval
  import ttt_pkg::*;
(
  input  cell_e       c0,
  input  cell_e       c1,
  input  cell_e       c2,
  input  cell_e       side,
  output logic        hit,
  output logic [1:0]  empty_idx
);

  logic [1:0] n_side;
  logic [1:0] n_empty;

  always_comb begin
    n_side  = 2'(c0 == side) + 2'(c1 == side) + 2'(c2 == side);
    n_empty = 2'(c0 == CELL_EMPTY) + 2'(c1 == CELL_EMPTY) + 2'(c2 == CELL_EMPTY);
    hit     = (n_side == 2'd2) && (n_empty == 2'd1);
    if (c0 == CELL_EMPTY)      empty_idx = 2'd0;
    else if (c1 == CELL_EMPTY) empty_idx = 2'd1;
    else                       empty_idx = 2'd2;
  end

endmodule

// File: rtl/ttt_computer_player.sv
// Computer opponent: after each accepted player move it scans the lines for
// a win, then a block, then falls back to a fixed positional order.
module ttt_computer_player
  import ttt_pkg::*;
#(
  parameter bit         COMPUTER_FIRST = 1'b0,
  parameter logic [3:0] FIRST_ADDR     = 4'd5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       player_move,
  input  logic       illegal_move,
  input  logic       win,
  input  logic       draw,
  input  logic [1:0] pos_led1,
  input  logic [1:0] pos_led2,
  input  logic [1:0] pos_led3,
  input  logic [1:0] pos_led4,
  input  logic [1:0] pos_led5,
  input  logic [1:0] pos_led6,
  input  logic [1:0] pos_led7,
  input  logic [1:0] pos_led8,
  input  logic [1:0] pos_led9,
  output logic       computer_move,
  output logic [3:0] computer_adderss,
  output logic       busy
);

  localparam state_e RST_STATE = COMPUTER_FIRST ? S_OPEN : S_WAIT_PLAYER;

  state_e     state_q, state_d;
  logic [2:0] line_idx_q, line_idx_d;
  logic       move_q, move_d;
  logic [3:0] addr_q, addr_d;

  cell_e      board [16];
  cell_e      side, c0, c1, c2;
  logic       hit;
  logic [1:0] empty_idx;
  logic [3:0] hit_addr, pick_addr, target;
  logic       pick_found;

  // Unused address slots read as occupied so they can never be chosen.
  always_comb begin
    for (int i = 0; i < 16; i++) board[i] = CELL_BLOCKED;
    board[1] = cell_e'(pos_led1);
    board[2] = cell_e'(pos_led2);
    board[3] = cell_e'(pos_led3);
    board[4] = cell_e'(pos_led4);
    board[5] = cell_e'(pos_led5);
    board[6] = cell_e'(pos_led6);
    board[7] = cell_e'(pos_led7);
    board[8] = cell_e'(pos_led8);
    board[9] = cell_e'(pos_led9);
  end

  assign side     = (state_q == S_SCAN_WIN) ? CELL_COMPUTER : CELL_PLAYER;
  assign c0       = board[line_cell(line_idx_q, 2'd0)];
  assign c1       = board[line_cell(line_idx_q, 2'd1)];
  assign c2       = board[line_cell(line_idx_q, 2'd2)];
  assign hit_addr = line_cell(line_idx_q, empty_idx);

  ttt_line_eval u_line_eval (
    .c0        (c0),
    .c1        (c1),
    .c2        (c2),
    .side      (side),
    .hit       (hit),
    .empty_idx (empty_idx)
  );

  // Walk the order backwards so the highest-priority empty cell wins.
  always_comb begin
    pick_addr  = 4'd0;
    pick_found = 1'b0;
    for (int i = 8; i >= 0; i--) begin
      if (board[pick_cell(i)] == CELL_EMPTY) begin
        pick_addr  = pick_cell(i);
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    line_idx_d = line_idx_q;
    addr_d     = addr_q;
    target     = addr_q;
    case (state_q)
      S_WAIT_PLAYER: if (player_move) state_d = S_SETTLE;
      S_OPEN: begin
        target  = FIRST_ADDR;
        state_d = S_ISSUE;
      end
      S_SETTLE: begin
        if (illegal_move) state_d = S_WAIT_PLAYER;
        else begin
          line_idx_d = 3'd0;
          state_d    = S_SCAN_WIN;
        end
      end
      S_SCAN_WIN, S_SCAN_BLOCK: begin
        if (hit) begin
          target  = hit_addr;
          state_d = S_ISSUE;
        end else begin
          line_idx_d = line_idx_q + 3'd1;
          if (line_idx_q == 3'd7)
            state_d = (state_q == S_SCAN_WIN) ? S_SCAN_BLOCK : S_PICK;
        end
      end
      S_PICK: begin
        target  = pick_addr;
        state_d = pick_found ? S_ISSUE : S_GAME_OVER;
      end
      S_ISSUE:     state_d = S_WAIT_PLAYER;
      S_GAME_OVER: state_d = S_GAME_OVER;
      default:     state_d = S_GAME_OVER;
    endcase
    // Game end overrides everything except a strobe already in flight.
    if ((win || draw) && state_q != S_ISSUE) state_d = S_GAME_OVER;
    move_d = (state_d == S_ISSUE);
    if (move_d) addr_d = target;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= RST_STATE;
      line_idx_q <= 3'd0;
      move_q     <= 1'b0;
      addr_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      line_idx_q <= line_idx_d;
      move_q     <= move_d;
      addr_q     <= addr_d;
    end
  end

  assign computer_move    = move_q;
  assign computer_adderss = addr_q;
  assign busy = (state_q == S_SETTLE) || (state_q == S_SCAN_WIN) ||
                (state_q == S_SCAN_BLOCK) || (state_q == S_PICK) ||
                (state_q == S_ISSUE);

endmodule
